// File: rtl/ifu_prefetch_pkg.sv
// Shared types and constants for the instruction prefetch unit.
// Fetch entries pair an instruction word with its byte address.
package ifu_prefetch_pkg;

    localparam logic [31:0] INST_NOP  = 32'h0000_0013;
    localparam logic [31:0] ZERO_WORD = 32'h0000_0000;

    localparam int          HOLD_W    = 3;
    localparam logic [2:0]  HOLD_IF   = 3'b001;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] inst;
    } fetch_entry_t;

    function automatic logic [31:0] word_align(
        input logic [31:0] a
    );
        return {a[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/ifu_prefetch_fetch_fifo.sv
// Small synchronous FIFO holding fetched {addr, inst} entries.
// Flush empties it in one cycle; push and pop may coincide when full.
import ifu_prefetch_pkg::*;

module fetch_fifo #(
    parameter int DEPTH = 2,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         push,
    input  logic         pop,
    input  fetch_entry_t wdata,
    output fetch_entry_t rdata,
    output logic [CW-1:0] count
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    fetch_entry_t   mem [DEPTH];
    logic [PW-1:0]  rd_ptr;
    logic [PW-1:0]  wr_ptr;
    logic           do_pop;
    logic           do_push;

    function automatic logic [PW-1:0] inc(
        input logic [PW-1:0] p
    );
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign do_pop  = pop && (count != '0);
    assign do_push = push && !flush &&
                     ((count < CW'(DEPTH)) || do_pop);
    assign rdata   = mem[rd_ptr];

    // Storage write; contents need no reset since count gates use.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointer and occupancy tracking.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= inc(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= inc(rd_ptr);
            end
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/ifu_prefetch.sv
// Instruction prefetch: PC generation, bus reads, FIFO buffering.
// Requests are credit-limited by buffered plus in-flight words.
import ifu_prefetch_pkg::*;

module ifu_prefetch #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              jump_flag_i,
    input  logic [31:0]       jump_addr_i,
    input  logic [HOLD_W-1:0] hold_flag_i,
    output logic              ibus_req_o,
    output logic [31:0]       ibus_addr_o,
    input  logic              ibus_gnt_i,
    input  logic              ibus_rvalid_i,
    input  logic [31:0]       ibus_rdata_i,
    output logic [31:0]       inst_o,
    output logic [31:0]       inst_addr_o,
    output logic              inst_valid_o
);

    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int QW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    logic [31:0]   pc;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] discard;
    logic [CW-1:0] outst_next;
    logic [CW-1:0] fifo_count;
    logic [CW:0]   occupancy;

    logic [31:0]   aq [FIFO_DEPTH];
    logic [QW-1:0] aq_wr;
    logic [QW-1:0] aq_rd;

    logic          hs;
    logic          drop;
    logic          push;
    logic          pop;
    fetch_entry_t  head;
    fetch_entry_t  wentry;

    function automatic logic [QW-1:0] qinc(
        input logic [QW-1:0] p
    );
        return (p == QW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign occupancy   = {1'b0, fifo_count} + {1'b0, outstanding};
    assign ibus_req_o  = !rst && !jump_flag_i &&
                         (occupancy < (CW + 1)'(FIFO_DEPTH));
    assign ibus_addr_o = pc;

    assign hs         = ibus_req_o && ibus_gnt_i;
    assign drop       = ibus_rvalid_i && (discard != '0);
    assign outst_next = outstanding + CW'(hs) - CW'(ibus_rvalid_i);

    assign push        = ibus_rvalid_i && !drop && !jump_flag_i;
    assign pop         = inst_valid_o && !jump_flag_i &&
                         (hold_flag_i < HOLD_IF);
    assign wentry.addr = aq[aq_rd];
    assign wentry.inst = ibus_rdata_i;

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH),
        .CW    (CW)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (jump_flag_i),
        .push  (push),
        .pop   (pop),
        .wdata (wentry),
        .rdata (head),
        .count (fifo_count)
    );

    assign inst_valid_o = (fifo_count != '0);
    assign inst_o       = inst_valid_o ? head.inst : INST_NOP;
    assign inst_addr_o  = inst_valid_o ? head.addr : ZERO_WORD;

    // PC advances on each accepted request; jumps redirect it.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc <= RESET_PC;
        end else if (jump_flag_i) begin
            pc <= word_align(jump_addr_i);
        end else if (hs) begin
            pc <= pc + 32'd4;
        end
    end

    // In-flight and stale-response counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            outstanding <= '0;
            discard     <= '0;
        end else begin
            outstanding <= outst_next;
            if (jump_flag_i) begin
                // everything still in flight now belongs to the old path
                discard <= outst_next;
            end else begin
                discard <= discard - CW'(drop);
            end
        end
    end

    // Address queue: request addresses wait here for their data.
    always_ff @(posedge clk) begin
        if (hs) begin
            aq[aq_wr] <= pc;
        end
    end

    // Address queue pointers follow grant and rvalid order.
    always_ff @(posedge clk) begin
        if (rst) begin
            aq_wr <= '0;
            aq_rd <= '0;
        end else begin
            if (hs) begin
                aq_wr <= qinc(aq_wr);
            end
            if (ibus_rvalid_i) begin
                aq_rd <= qinc(aq_rd);
            end
        end
    end

    rvalid_has_credit: assert property (
        @(posedge clk) disable iff (rst)
        ibus_rvalid_i |-> (outstanding != '0)
    );

endmodule

// File: tb/tb_ifu_prefetch.sv
// Randomized bench for ifu_prefetch against a queue-based model.
// Directed segments pin reset, hold, stall, jump and wrap behaviour.
module tb_ifu_prefetch;
    import ifu_prefetch_pkg::*;

    localparam int          DEPTH = 2;
    localparam logic [31:0] RPC   = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        jump_flag_i = 1'b0;
    logic [31:0] jump_addr_i = '0;
    logic [2:0]  hold_flag_i = '0;
    logic        ibus_req_o;
    logic [31:0] ibus_addr_o;
    logic        ibus_gnt_i = 1'b0;
    logic        ibus_rvalid_i = 1'b0;
    logic [31:0] ibus_rdata_i = '0;
    logic [31:0] inst_o;
    logic [31:0] inst_addr_o;
    logic        inst_valid_o;

    always #5 clk = ~clk;

    ifu_prefetch #(
        .RESET_PC   (RPC),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .jump_flag_i   (jump_flag_i),
        .jump_addr_i   (jump_addr_i),
        .hold_flag_i   (hold_flag_i),
        .ibus_req_o    (ibus_req_o),
        .ibus_addr_o   (ibus_addr_o),
        .ibus_gnt_i    (ibus_gnt_i),
        .ibus_rvalid_i (ibus_rvalid_i),
        .ibus_rdata_i  (ibus_rdata_i),
        .inst_o        (inst_o),
        .inst_addr_o   (inst_addr_o),
        .inst_valid_o  (inst_valid_o)
    );

    typedef struct {
        logic [31:0] addr;
        bit          stale;
    } fl_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] inst;
    } wd_t;

    fl_t         infl[$];
    wd_t         fq[$];
    logic [31:0] mpc = RPC;
    logic        exp_req;
    int          errors = 0;
    int          checks = 0;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hC0DE_0000;
    endfunction

    task automatic chk(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic compare();
        exp_req = !rst && !jump_flag_i &&
                  ((fq.size() + infl.size()) < DEPTH);
        chk("req", 32'(ibus_req_o), 32'(exp_req));
        chk("addr", ibus_addr_o, mpc);
        if (fq.size() > 0) begin
            chk("valid", 32'(inst_valid_o), 32'd1);
            chk("inst", inst_o, fq[0].inst);
            chk("inst_addr", inst_addr_o, fq[0].addr);
        end else begin
            chk("valid", 32'(inst_valid_o), 32'd0);
            chk("inst", inst_o, INST_NOP);
            chk("inst_addr", inst_addr_o, ZERO_WORD);
        end
    endtask

    task automatic drive(input bit r, input bit j,
                         input logic [31:0] ja,
                         input logic [2:0] h,
                         input bit g, input int rvp);
        @(negedge clk);
        rst         = r;
        jump_flag_i = j;
        jump_addr_i = ja;
        hold_flag_i = h;
        ibus_gnt_i  = g;
        if (!r && infl.size() > 0 &&
            int'($urandom_range(0, 99)) < rvp) begin
            ibus_rvalid_i = 1'b1;
            ibus_rdata_i  = memf(infl[0].addr);
        end else begin
            ibus_rvalid_i = 1'b0;
            ibus_rdata_i  = $urandom;
        end
        #1;
        compare();
    endtask

    task automatic advance();
        fl_t e;
        bit  hs;
        if (rst) begin
            infl.delete();
            fq.delete();
            mpc = RPC;
        end else begin
            hs = exp_req && ibus_gnt_i;
            if (fq.size() > 0 && hold_flag_i == 3'd0 && !jump_flag_i)
                void'(fq.pop_front());
            if (ibus_rvalid_i) begin
                e = infl.pop_front();
                if (!e.stale && !jump_flag_i)
                    fq.push_back('{e.addr, memf(e.addr)});
            end
            if (jump_flag_i) begin
                fq.delete();
                foreach (infl[i]) infl[i].stale = 1'b1;
                mpc = {jump_addr_i[31:2], 2'b00};
            end else if (hs) begin
                infl.push_back('{mpc, 1'b0});
                mpc = mpc + 32'd4;
            end
        end
        @(posedge clk);
    endtask

    task automatic cyc(input bit r, input bit j,
                       input logic [31:0] ja,
                       input logic [2:0] h,
                       input bit g, input int rvp);
        drive(r, j, ja, h, g, rvp);
        advance();
    endtask

    initial begin
        logic [31:0] a0;
        bit          seen;
        int          rvp;
        logic [31:0] ja;

        cyc(1, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0);

        // reset release, streaming
        drive(0, 0, 0, 0, 1, 100);
        chk("t1_req0", 32'(ibus_req_o), 32'd1);
        chk("t1_addr0", ibus_addr_o, 32'h0);
        chk("t1_nop", inst_o, 32'h0000_0013);
        advance();
        drive(0, 0, 0, 0, 1, 100);
        chk("t1_addr1", ibus_addr_o, 32'h4);
        chk("t1_valid_b", 32'(inst_valid_o), 32'd0);
        advance();
        drive(0, 0, 0, 0, 1, 100);
        chk("t1_valid_c", 32'(inst_valid_o), 32'd1);
        chk("t1_iaddr0", inst_addr_o, 32'h0);
        chk("t1_credit", 32'(ibus_req_o), 32'd0);
        advance();
        drive(0, 0, 0, 0, 1, 100);
        chk("t1_addr2", ibus_addr_o, 32'h8);
        chk("t1_iaddr1", inst_addr_o, 32'h4);
        advance();
        cyc(0, 0, 0, 0, 1, 100);
        drive(0, 0, 0, 0, 1, 100);
        chk("t1_iaddr2", inst_addr_o, 32'h8);
        advance();

        // hold fills the buffer, then drains in order
        for (int k = 0; k < 5; k++) cyc(0, 0, 0, 3'd1, 1, 100);
        drive(0, 0, 0, 3'd1, 1, 100);
        chk("t2_full_valid", 32'(inst_valid_o), 32'd1);
        chk("t2_full_noreq", 32'(ibus_req_o), 32'd0);
        advance();
        for (int k = 0; k < 6; k++) cyc(0, 0, 0, 0, 0, 100);

        // grant stall keeps the address stable
        a0 = mpc;
        for (int k = 0; k < 3; k++) begin
            drive(0, 0, 0, 0, 0, 100);
            chk("t3_req", 32'(ibus_req_o), 32'd1);
            chk("t3_stable", ibus_addr_o, a0);
            advance();
        end
        cyc(0, 0, 0, 3'd1, 1, 0);
        drive(0, 0, 0, 3'd1, 1, 0);
        chk("t3_adv", ibus_addr_o, a0 + 32'd4);
        advance();

        // jump with two requests in flight
        drive(0, 1, 32'h0000_0103, 3'd1, 0, 0);
        chk("t4_jreq", 32'(ibus_req_o), 32'd0);
        advance();
        seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            drive(0, 0, 0, 0, 1, 100);
            if (k == 0) chk("t4_addr", ibus_addr_o, 32'h100);
            if (inst_valid_o) begin
                seen = 1'b1;
                chk("t4_first", inst_addr_o, 32'h100);
            end
            advance();
        end
        chk("t4_timeout", 32'(seen), 32'd1);

        // jump and rvalid together while held
        for (int k = 0; k < 4; k++) cyc(0, 0, 0, 0, 0, 100);
        for (int k = 0; k < 3; k++) cyc(0, 0, 0, 3'd1, 1, 0);
        cyc(0, 0, 0, 3'd1, 0, 100);
        drive(0, 1, 32'h0000_0040, 3'd1, 0, 100);
        chk("t5_rv", 32'(ibus_rvalid_i), 32'd1);
        advance();
        drive(0, 0, 0, 3'd1, 0, 0);
        chk("t5_valid", 32'(inst_valid_o), 32'd0);
        chk("t5_nop", inst_o, 32'h0000_0013);
        advance();

        // reset mid-stream
        for (int k = 0; k < 6; k++) cyc(0, 0, 0, 0, 1, 60);
        cyc(1, 0, 0, 0, 1, 0);
        drive(0, 0, 0, 0, 0, 0);
        chk("t6_valid", 32'(inst_valid_o), 32'd0);
        chk("t6_nop", inst_o, 32'h0000_0013);
        chk("t6_iaddr", inst_addr_o, 32'h0);
        chk("t6_pc", ibus_addr_o, RPC);
        chk("t6_req", 32'(ibus_req_o), 32'd1);
        advance();

        // pc wrap at the top of the address space
        cyc(0, 1, 32'hFFFF_FFFE, 0, 0, 0);
        drive(0, 0, 0, 0, 1, 0);
        chk("wrap_top", ibus_addr_o, 32'hFFFF_FFFC);
        advance();
        drive(0, 0, 0, 0, 0, 100);
        chk("wrap_zero", ibus_addr_o, 32'h0);
        advance();

        // randomized traffic
        rvp = 60;
        for (int c = 0; c < 3000; c++) begin
            if (c % 500 == 0) rvp = int'($urandom_range(20, 100));
            ja = $urandom;
            if ($urandom_range(0, 3) == 0) ja = 32'hFFFF_FFF0 | (ja & 32'hF);
            cyc($urandom_range(0, 99) == 0,
                $urandom_range(0, 99) < 4,
                ja,
                ($urandom_range(0, 3) == 0) ? 3'($urandom_range(1, 7)) : 3'd0,
                $urandom_range(0, 99) < 70,
                rvp);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
